// File: rtl/user_obi_dma.sv
// Single-channel word-copy DMA: a small register file on the config port,
// and an OBI manager that moves LEN words from SRC to DST, one read then one
// write per word, with at most one transaction outstanding.

package user_obi_dma_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        rid;
  } obi_rsp_t;

endpackage

module user_obi_dma #(
  parameter int unsigned AddrWidth     = 32,
  parameter type         reg_req_t     = user_obi_dma_pkg::reg_req_t,
  parameter type         reg_rsp_t     = user_obi_dma_pkg::reg_rsp_t,
  parameter type         mgr_obi_req_t = user_obi_dma_pkg::obi_req_t,
  parameter type         mgr_obi_rsp_t = user_obi_dma_pkg::obi_rsp_t
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  reg_req_t     reg_req_i,
  output reg_rsp_t     reg_rsp_o,
  output mgr_obi_req_t user_mgr_obi_req_o,
  input  mgr_obi_rsp_t user_mgr_obi_rsp_i,
  output logic         irq_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FINISH  = 3'd5
  } state_e;

  localparam logic [4:0] OffSrc    = 5'h00;
  localparam logic [4:0] OffDst    = 5'h04;
  localparam logic [4:0] OffLen    = 5'h08;
  localparam logic [4:0] OffCtrl   = 5'h0C;
  localparam logic [4:0] OffStatus = 5'h10;

  // Byte-strobe merge of a register write into the current register value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_reg_q, dst_reg_q;
  logic [15:0]          len_q;
  logic [AddrWidth-1:0] src_q, dst_q;
  logic [15:0]          cnt_q;
  logic [31:0]          buf_q;
  logic                 done_q, err_q, irq_q;

  logic [4:0]  off_s;
  logic        wr_en_s, busy_s, start_s, clr_s, rsp_ok_s, rsp_err_s;
  logic [31:0] src_merge_s, dst_merge_s, len_merge_s;

  assign off_s   = reg_req_i.addr[4:0];
  assign wr_en_s = reg_req_i.valid & reg_req_i.write;
  assign busy_s  = (state_q != IDLE);
  assign start_s = wr_en_s & (off_s == OffCtrl) & reg_req_i.wdata[0] & ~busy_s;
  assign clr_s   = wr_en_s & (off_s == OffCtrl) & reg_req_i.wdata[1];

  // A response only counts while the FSM is actually waiting for one.
  assign rsp_ok_s  = user_mgr_obi_rsp_i.rvalid & ((state_q == RD_WAIT) | (state_q == WR_WAIT));
  assign rsp_err_s = rsp_ok_s & user_mgr_obi_rsp_i.err;

  assign src_merge_s = strb_merge(32'(src_reg_q), reg_req_i.wdata, reg_req_i.wstrb);
  assign dst_merge_s = strb_merge(32'(dst_reg_q), reg_req_i.wdata, reg_req_i.wstrb);
  assign len_merge_s = strb_merge({16'h0000, len_q}, reg_req_i.wdata, reg_req_i.wstrb);

  assign irq_o = irq_q;

  // Config read mux and error decode; the port never stalls.
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    case (off_s)
      OffSrc:    reg_rsp_o.rdata = 32'(src_reg_q);
      OffDst:    reg_rsp_o.rdata = 32'(dst_reg_q);
      OffLen:    reg_rsp_o.rdata = {16'h0000, len_q};
      OffCtrl:   reg_rsp_o.rdata = 32'h0000_0000;
      OffStatus: begin
        reg_rsp_o.rdata = {29'h0, err_q, done_q, busy_s};
        reg_rsp_o.error = wr_en_s;
      end
      default:   reg_rsp_o.error = reg_req_i.valid;
    endcase
  end

  // Next-state logic and OBI a-channel, driven purely from registered state
  // so the request stays stable until granted.
  always_comb begin
    state_d                   = state_q;
    user_mgr_obi_req_o        = '0;
    user_mgr_obi_req_o.rready = 1'b1;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = (len_q == 16'd0) ? FINISH : RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        user_mgr_obi_req_o.req  = 1'b1;
        user_mgr_obi_req_o.addr = 32'(src_q);
        user_mgr_obi_req_o.be   = 4'hF;
        if (user_mgr_obi_rsp_i.gnt) begin
          state_d = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (rsp_ok_s) begin
          state_d = rsp_err_s ? FINISH : WR_REQ;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_REQ: begin
        user_mgr_obi_req_o.req   = 1'b1;
        user_mgr_obi_req_o.addr  = 32'(dst_q);
        user_mgr_obi_req_o.we    = 1'b1;
        user_mgr_obi_req_o.be    = 4'hF;
        user_mgr_obi_req_o.wdata = buf_q;
        if (user_mgr_obi_rsp_i.gnt) begin
          state_d = WR_WAIT;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_WAIT: begin
        if (rsp_ok_s) begin
          state_d = (rsp_err_s || (cnt_q == 16'd1)) ? FINISH : RD_REQ;
        end else begin
          state_d = WR_WAIT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Software-visible SRC/DST/LEN; frozen while a transfer runs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_reg_q <= '0;
      dst_reg_q <= '0;
      len_q     <= 16'd0;
    end else if (wr_en_s && !busy_s) begin
      case (off_s)
        OffSrc:  src_reg_q <= AddrWidth'(src_merge_s) & ~AddrWidth'(32'd3);
        OffDst:  dst_reg_q <= AddrWidth'(dst_merge_s) & ~AddrWidth'(32'd3);
        OffLen:  len_q     <= len_merge_s[15:0];
        default: len_q     <= len_q;
      endcase
    end
  end

  // Working pointers, remaining count and the single-word data buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= 16'd0;
      buf_q <= 32'h0000_0000;
    end else if (start_s) begin
      src_q <= src_reg_q;
      dst_q <= dst_reg_q;
      cnt_q <= len_q;
    end else if (rsp_ok_s && !rsp_err_s && (state_q == RD_WAIT)) begin
      buf_q <= user_mgr_obi_rsp_i.rdata;
    end else if (rsp_ok_s && !rsp_err_s && (state_q == WR_WAIT)) begin
      src_q <= src_q + AddrWidth'(32'd4);
      dst_q <= dst_q + AddrWidth'(32'd4);
      cnt_q <= cnt_q - 16'd1;
    end
  end

  // Sticky done/err flags (cleared by software or a new start) and the
  // completion pulse, which follows the single FINISH cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      irq_q <= (state_q == FINISH);
      if (clr_s || start_s) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (state_q == FINISH) begin
        done_q <= 1'b1;
      end
      if (rsp_err_s) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_user_obi_dma.sv
// Bench for user_obi_dma: register vector table, then copy scenarios against
// a small OBI memory with a write scoreboard.
module tb_user_obi_dma;
  import user_obi_dma_pkg::*;

  logic     clk;
  logic     rst_ni;
  reg_req_t rq;
  reg_rsp_t rs;
  obi_req_t oreq;
  obi_rsp_t orsp;
  logic     irq;

  int checks   = 0;
  int failures = 0;

  user_obi_dma #(.AddrWidth(32)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .reg_req_i          (rq),
    .reg_rsp_o          (rs),
    .user_mgr_obi_req_o (oreq),
    .user_mgr_obi_rsp_i (orsp),
    .irq_o              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- OBI subordinate model + write scoreboard --------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mem [logic [31:0]];
  wr_t         exp_q[$];
  bit          trace[$];
  int          stall_left  = 0;
  int          stall_seen  = 0;
  int          err_wr_idx  = 0;
  int          wr_count    = 0;
  int          req_count   = 0;
  int          irq_cnt     = 0;
  int          viol        = 0;
  bit          pend        = 1'b0;
  logic [31:0] sv_addr, sv_wd;
  logic        sv_we;
  logic [3:0]  sv_be;
  logic        rvalid_q = 1'b0;
  logic        rerr_q   = 1'b0;
  logic [31:0] rdata_q  = 32'h0;

  always_comb begin
    orsp        = '0;
    orsp.gnt    = oreq.req && (stall_left == 0);
    orsp.rvalid = rvalid_q;
    orsp.rdata  = rdata_q;
    orsp.err    = rerr_q;
  end

  always @(posedge clk) begin
    wr_t e;
    rvalid_q <= 1'b0;
    rerr_q   <= 1'b0;
    if (irq) irq_cnt++;
    if (oreq.req && !orsp.gnt) begin
      if (pend && (oreq.addr !== sv_addr || oreq.we !== sv_we ||
                   oreq.wdata !== sv_wd || oreq.be !== sv_be)) viol++;
      pend = 1'b1;
      sv_addr = oreq.addr; sv_we = oreq.we; sv_wd = oreq.wdata; sv_be = oreq.be;
      stall_left--;
      stall_seen++;
    end else begin
      pend = 1'b0;
    end
    if (oreq.req && orsp.gnt) begin
      req_count++;
      trace.push_back(oreq.we);
      rvalid_q <= 1'b1;
      if (oreq.we) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", oreq.addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_wr_addr", oreq.addr, e.a);
          check("sb_wr_data", oreq.wdata, e.d);
        end
        if (wr_count == err_wr_idx) rerr_q <= 1'b1;
        else mem[oreq.addr] = oreq.wdata;
      end else begin
        rdata_q <= mem.exists(oreq.addr) ? mem[oreq.addr] : 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- register access helpers ----------------------------
  task automatic reg_acc(input logic [4:0] off, input bit wr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
    @(negedge clk);
    rq       = '0;
    rq.addr  = 32'h0300_0000 | {27'h0, off};
    rq.write = wr;
    rq.wdata = wd;
    rq.wstrb = 4'hF;
    rq.valid = 1'b1;
    #1;
    rd  = rs.rdata;
    err = rs.error;
    @(posedge clk);
    #1;
    rq = '0;
  endtask

  task automatic reg_wr(input logic [4:0] off, input logic [31:0] wd);
    logic [31:0] rd;
    logic        err;
    reg_acc(off, 1'b1, wd, rd, err);
  endtask

  task automatic reg_rd(input logic [4:0] off, output logic [31:0] rd);
    logic err;
    reg_acc(off, 1'b0, 32'h0, rd, err);
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0FF_EE00;
  endfunction

  task automatic setup_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int errw);
    int  nwr;
    wr_t e;
    for (int i = 0; i < len; i++) begin
      mem[src + 32'(4*i)] = pat(src + 32'(4*i));
      mem[dst + 32'(4*i)] = 32'h5EA1_0000 | 32'(i);
    end
    nwr = (errw != 0 && errw <= len) ? errw : len;
    exp_q.delete();
    for (int i = 0; i < nwr; i++) begin
      e.a = dst + 32'(4*i);
      e.d = pat(src + 32'(4*i));
      exp_q.push_back(e);
    end
    err_wr_idx = errw;
    wr_count   = 0;
    req_count  = 0;
    trace.delete();
    reg_wr(5'h00, src);
    reg_wr(5'h04, dst);
    reg_wr(5'h08, 32'(len));
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (irq) got = 1'b1;
    end
    check({tag, "_irq_seen"}, {31'h0, got}, 32'h1);
    @(negedge clk);
    check({tag, "_irq_one_cycle"}, {31'h0, irq}, 32'h0);
  endtask

  // ---------------- register vector table ---------------------------------
  typedef struct {
    logic [4:0]  off;
    bit          wr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [7:0]  tv;
    int          ic;

    vecs[0]  = '{5'h00, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[1]  = '{5'h04, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[2]  = '{5'h08, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[3]  = '{5'h10, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[4]  = '{5'h00, 1'b1, 32'h3,         1'b0, 32'h0,         1'b0};
    vecs[5]  = '{5'h00, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[6]  = '{5'h00, 1'b1, 32'h1234_5677, 1'b0, 32'h0,         1'b0};
    vecs[7]  = '{5'h00, 1'b0, 32'h0,         1'b1, 32'h1234_5674, 1'b0};
    vecs[8]  = '{5'h04, 1'b1, 32'h0000_ABCD, 1'b0, 32'h0,         1'b0};
    vecs[9]  = '{5'h04, 1'b0, 32'h0,         1'b1, 32'h0000_ABCC, 1'b0};
    vecs[10] = '{5'h08, 1'b1, 32'hFFFF_1234, 1'b0, 32'h0,         1'b0};
    vecs[11] = '{5'h08, 1'b0, 32'h0,         1'b1, 32'h0000_1234, 1'b0};
    vecs[12] = '{5'h0C, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[13] = '{5'h14, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
    vecs[14] = '{5'h10, 1'b1, 32'h7,         1'b0, 32'h0,         1'b1};
    vecs[15] = '{5'h10, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[16] = '{5'h1C, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};

    rq     = '0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req", {31'h0, oreq.req}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      reg_acc(vecs[i].off, vecs[i].wr, vecs[i].wdata, rd, err);
      check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Plain 4-word copy: strict R,W interleave and one irq.
    setup_copy(32'h1000_0000, 32'h1000_0100, 4, 0);
    ic = irq_cnt;
    reg_wr(5'h0C, 32'h1);
    wait_done("copy4");
    check("copy4_irq_count", 32'(irq_cnt - ic), 32'h1);
    reg_rd(5'h10, rd);
    check("copy4_status", rd, 32'h2);
    check("copy4_req_count", 32'(req_count), 32'd8);
    tv = '0;
    for (int i = 0; i < 8 && i < trace.size(); i++) tv[i] = trace[i];
    check("copy4_order", {24'h0, tv}, 32'h0000_00AA);
    for (int i = 0; i < 4; i++)
      check($sformatf("copy4_mem%0d", i), mem[32'h1000_0100 + 32'(4*i)],
            pat(32'h1000_0000 + 32'(4*i)));
    check("copy4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length start: no bus traffic, irq two cycles after the write.
    setup_copy(32'h2000_0000, 32'h2000_0100, 0, 0);
    reg_wr(5'h0C, 32'h1);
    @(negedge clk);
    check("len0_irq_early", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("len0_irq_pulse", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check("len0_irq_end", {31'h0, irq}, 32'h0);
    reg_rd(5'h10, rd);
    check("len0_status", rd, 32'h2);
    check("len0_no_req", 32'(req_count), 32'd0);

    // First read stalled 5 cycles; LEN write while busy is dropped.
    setup_copy(32'h1000_0200, 32'h1000_0300, 2, 0);
    stall_left = 5;
    stall_seen = 0;
    reg_wr(5'h0C, 32'h3);
    reg_wr(5'h08, 32'h77);
    reg_rd(5'h08, rd);
    check("busy_len_unchanged", rd, 32'h2);
    reg_rd(5'h10, rd);
    check("busy_status", rd, 32'h1);
    wait_done("stall");
    check("stall_cycles", 32'(stall_seen), 32'd5);
    check("stall_stable", 32'(viol), 32'd0);
    reg_rd(5'h10, rd);
    check("stall_status", rd, 32'h2);
    check("stall_mem1", mem[32'h1000_0304], pat(32'h1000_0204));

    // Error on the second write of a 3-word copy.
    setup_copy(32'h1000_0400, 32'h1000_0500, 3, 2);
    reg_wr(5'h0C, 32'h1);
    wait_done("err");
    reg_rd(5'h10, rd);
    check("err_status", rd, 32'h6);
    check("err_req_count", 32'(req_count), 32'd4);
    check("err_mem0", mem[32'h1000_0500], pat(32'h1000_0400));
    check("err_mem1", mem[32'h1000_0504], 32'h5EA1_0001);
    check("err_mem2", mem[32'h1000_0508], 32'h5EA1_0002);
    check("err_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while a write request is pending.
    setup_copy(32'h1000_0600, 32'h1000_0700, 2, 0);
    reg_wr(5'h0C, 32'h1);
    ic = 0;
    for (int n = 0; n < 50 && ic == 0; n++) begin
      @(negedge clk);
      if (oreq.req && oreq.we) ic = 1;
    end
    check("rst_saw_wr_req", 32'(ic), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rst_req_drop", {31'h0, oreq.req}, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    reg_rd(5'h10, rd);
    check("rst_status", rd, 32'h0);
    reg_rd(5'h00, rd);
    check("rst_src", rd, 32'h0);
    reg_rd(5'h08, rd);
    check("rst_len", rd, 32'h0);
    setup_copy(32'h1000_0800, 32'h1000_0900, 1, 0);
    reg_wr(5'h0C, 32'h1);
    wait_done("post_rst");
    reg_rd(5'h10, rd);
    check("post_rst_status", rd, 32'h2);
    check("post_rst_mem", mem[32'h1000_0900], pat(32'h1000_0800));
    check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
    check("all_stable", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
